// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file and its clear sequencer.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_if.sv
// Operand-fetch / writeback bus of the register file: two read ports, pair read, write port, clear control.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) ();

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]   rs1_addr;
    logic [ADDR_W-1:0]   rs2_addr;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic [2*DATA_W-1:0] rp_data;
    logic                wr_en;
    logic                wr_pair;
    logic [ADDR_W-1:0]   wr_addr;
    logic [2*DATA_W-1:0] wr_data;
    logic                clr_req;
    logic                busy;
    logic                wr_err;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_pair, wr_addr, wr_data, clr_req,
        input  rs1_data, rs2_data, rp_data, busy, wr_err
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_pair, wr_addr, wr_data, clr_req,
        output rs1_data, rs2_data, rp_data, busy, wr_err
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks the array one entry per cycle and flags writes dropped while it runs.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr_req,
    input  logic              i_wr_en,
    output logic              o_busy,
    output logic              o_wr_err,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    clr_state_e        r_state;
    clr_state_e        w_state_next;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_next;
    logic              r_wr_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_clr_ptr <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
            r_wr_err  <= i_wr_en && (r_state == ST_CLEAR);
        end
    end

    // clr_req is only looked at in IDLE, so a request during a sweep is simply lost
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_ptr_next = '0;
                end
            end
            ST_CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == LAST_PTR) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == ST_CLEAR);
    assign o_clr_en   = (r_state == ST_CLEAR);
    assign o_clr_addr = r_clr_ptr;
    assign o_wr_err   = r_wr_err;

endmodule

// File: rtl/regfile_pair.sv
// General-purpose register file: two forwarded read ports, pair read, single/pair write, hardware clear.
module regfile_pair
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               ADDR_W    = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     reset_n,
    regfile_if.slave bus
);

    logic [DATA_W-1:0]   r_regs [DEPTH];
    logic                w_busy;
    logic                w_wr_err;
    logic                w_clr_en;
    logic [ADDR_W-1:0]   w_clr_addr;
    logic                w_wr_go;
    logic                w_wr_pair;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_wr_addr_nxt;
    logic [ADDR_W-1:0]   w_rs1_addr_nxt;
    logic [DATA_W-1:0]   w_wr_hi;
    logic [DATA_W-1:0]   w_wr_lo;
    logic [DATA_W-1:0]   w_rs1_data;
    logic [DATA_W-1:0]   w_rs2_data;
    logic [2*DATA_W-1:0] w_rp_data;

    regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr_req  (bus.clr_req),
        .i_wr_en    (bus.wr_en),
        .o_busy     (w_busy),
        .o_wr_err   (w_wr_err),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    // Writes are only accepted outside a clear sweep; the same gate controls forwarding.
    assign w_wr_go        = bus.wr_en & ~w_busy;
    assign w_wr_pair      = bus.wr_pair;
    assign w_wr_addr      = bus.wr_addr;
    assign w_wr_addr_nxt  = bus.wr_addr + 1'b1;
    assign w_rs1_addr_nxt = bus.rs1_addr + 1'b1;
    assign w_wr_hi        = bus.wr_pair ? bus.wr_data[2*DATA_W-1:DATA_W] : bus.wr_data[DATA_W-1:0];
    assign w_wr_lo        = bus.wr_data[DATA_W-1:0];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_regs[gi] <= RESET_VAL;
            end else if (w_clr_en && (w_clr_addr == IDX)) begin
                r_regs[gi] <= RESET_VAL;
            end else if (w_wr_go && (w_wr_addr == IDX)) begin
                r_regs[gi] <= w_wr_hi;
            end else if (w_wr_go && w_wr_pair && (w_wr_addr_nxt == IDX)) begin
                r_regs[gi] <= w_wr_lo;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_fwd(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = r_regs[addr];
        if (w_wr_go && (addr == w_wr_addr)) begin
            val = w_wr_hi;
        end else if (w_wr_go && w_wr_pair && (addr == w_wr_addr_nxt)) begin
            val = w_wr_lo;
        end
        return val;
    endfunction

    always_comb begin
        w_rs1_data = read_fwd(bus.rs1_addr);
        w_rs2_data = read_fwd(bus.rs2_addr);
        w_rp_data  = {read_fwd(bus.rs1_addr), read_fwd(w_rs1_addr_nxt)};
    end

    assign bus.rs1_data = w_rs1_data;
    assign bus.rs2_data = w_rs2_data;
    assign bus.rp_data  = w_rp_data;
    assign bus.busy     = w_busy;
    assign bus.wr_err   = w_wr_err;

endmodule

// File: tb/tb_regfile_pair.sv
// Self-checking bench for regfile_pair: directed scenarios plus randomized traffic against an array model.
module tb_regfile_pair;
    import regfile_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    regfile_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    regfile_pair #(.DATA_W(DW), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Reference model: register contents, remaining clear cycles, pending error flag.
    logic [DW-1:0] m_regs [DEPTH];
    int            m_left;
    int            m_idx;
    logic          m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) m_regs[i] <= '0;
            m_left <= 0;
            m_idx  <= 0;
            m_err  <= 1'b0;
        end else if (m_left > 0) begin
            m_regs[m_idx] <= '0;
            m_idx         <= m_idx + 1;
            m_left        <= m_left - 1;
            m_err         <= bus.wr_en;
        end else begin
            m_err <= 1'b0;
            if (bus.wr_en) begin
                if (bus.wr_pair) begin
                    m_regs[bus.wr_addr]                        <= bus.wr_data[15:8];
                    m_regs[(int'(bus.wr_addr) + 1) % DEPTH]    <= bus.wr_data[7:0];
                end else begin
                    m_regs[bus.wr_addr] <= bus.wr_data[7:0];
                end
            end
            if (bus.clr_req) begin
                m_left <= DEPTH;
                m_idx  <= 0;
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (bus.wr_en && (m_left == 0)) begin
            if (a == bus.wr_addr) return bus.wr_pair ? bus.wr_data[15:8] : bus.wr_data[7:0];
            if (bus.wr_pair && (int'(a) == (int'(bus.wr_addr) + 1) % DEPTH)) return bus.wr_data[7:0];
        end
        return m_regs[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.wr_en    = 1'b0;
        bus.wr_pair  = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rs1_addr = AW'(i);
            bus.rs2_addr = AW'(DEPTH - 1 - i);
            #1;
            checks++;
            if (bus.rs1_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rs1 addr=%0d got=%h exp=00", i, bus.rs1_data);
            end
            checks++;
            if (bus.rs2_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rs2 addr=%0d got=%h exp=00", DEPTH - 1 - i, bus.rs2_data);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_err got=%b exp=0", bus.wr_err);
        end
        $display("test_reset: all %0d registers read back", DEPTH);
        tick();
    endtask

    task automatic test_single_fwd();
        drive_idle();
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd3;
        bus.wr_data  = 16'h00A5;
        bus.rs1_addr = 3'd3;
        #1;
        checks++;
        if (bus.rs1_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_fwd got=%h exp=a5", bus.rs1_data);
        end
        tick();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.rs1_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_array got=%h exp=a5", bus.rs1_data);
        end
        $display("test_single_fwd: wr reg3=a5 read=%h", bus.rs1_data);
        tick();
    endtask

    task automatic test_pair_wrap();
        drive_idle();
        bus.wr_en    = 1'b1;
        bus.wr_pair  = 1'b1;
        bus.wr_addr  = 3'd7;
        bus.wr_data  = 16'hBEEF;
        bus.rs1_addr = 3'd7;
        bus.rs2_addr = 3'd0;
        #1;
        checks++;
        if (bus.rp_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL pair_fwd_rp got=%h exp=beef", bus.rp_data);
        end
        checks++;
        if (bus.rs2_data !== 8'hEF) begin
            errors++;
            $display("FAIL pair_fwd_lo got=%h exp=ef", bus.rs2_data);
        end
        tick();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.rp_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL pair_array_rp got=%h exp=beef", bus.rp_data);
        end
        checks++;
        if (bus.rs1_data !== 8'hBE) begin
            errors++;
            $display("FAIL pair_reg7 got=%h exp=be", bus.rs1_data);
        end
        checks++;
        if (bus.rs2_data !== 8'hEF) begin
            errors++;
            $display("FAIL pair_reg0 got=%h exp=ef", bus.rs2_data);
        end
        $display("test_pair_wrap: wr pair@7=beef rp=%h", bus.rp_data);
        tick();
    endtask

    task automatic test_clear();
        int nb;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(i);
            bus.wr_data = {8'h00, 8'(17 * (i + 1))};
            tick();
        end
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        nb = 0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            bus.wr_en   = (k == 1);
            bus.wr_addr = 3'd5;
            bus.wr_data = 16'h00EE;
            #1;
            if (k == 2) begin
                checks++;
                if (bus.wr_err !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_wr_err_pulse got=%b exp=1", bus.wr_err);
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.wr_err !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_wr_err_len got=%b exp=0", bus.wr_err);
                end
            end
            if (!bus.busy) break;
            nb++;
            tick();
        end
        bus.wr_en = 1'b0;
        checks++;
        if (nb != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_cycles got=%0d exp=%0d", nb, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.rs1_addr = AW'(i);
            #1;
            checks++;
            if (bus.rs1_data !== 8'h00) begin
                errors++;
                $display("FAIL clear_reg addr=%0d got=%h exp=00", i, bus.rs1_data);
            end
        end
        $display("test_clear: busy for %0d cycles", nb);
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int nb;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(i);
            bus.wr_data = 16'($urandom_range(1, 255));
            tick();
        end
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midclr_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("FAIL midclr_wr_err got=%b exp=0", bus.wr_err);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.rs1_addr = AW'(i);
            #1;
            checks++;
            if (bus.rs1_data !== 8'h00) begin
                errors++;
                $display("FAIL midclr_reg addr=%0d got=%h exp=00", i, bus.rs1_data);
            end
        end
        reset_n = 1'b1;
        tick();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        nb = 0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            #1;
            if (!bus.busy) break;
            nb++;
            tick();
        end
        checks++;
        if (nb != DEPTH) begin
            errors++;
            $display("FAIL midclr_rerun_cycles got=%0d exp=%0d", nb, DEPTH);
        end
        $display("test_reset_mid_clear: rerun busy %0d cycles", nb);
        tick();
    endtask

    task automatic test_clr_and_write();
        drive_idle();
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 16'h005A;
        bus.clr_req  = 1'b1;
        bus.rs1_addr = 3'd0;
        #1;
        checks++;
        if (bus.rs1_data !== 8'h5A) begin
            errors++;
            $display("FAIL clrwr_fwd got=%h exp=5a", bus.rs1_data);
        end
        tick();
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b0;
        #1;
        checks++;
        if (bus.rs1_data !== 8'h5A) begin
            errors++;
            $display("FAIL clrwr_stored got=%h exp=5a", bus.rs1_data);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL clrwr_busy got=%b exp=1", bus.busy);
        end
        tick();
        checks++;
        if (bus.rs1_data !== 8'h00) begin
            errors++;
            $display("FAIL clrwr_cleared got=%h exp=00", bus.rs1_data);
        end
        for (int k = 0; k < 4 * DEPTH; k++) begin
            if (!bus.busy) break;
            tick();
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clrwr_drain got=%b exp=0", bus.busy);
        end
        $display("test_clr_and_write: reg0 5a then %h", bus.rs1_data);
        tick();
    endtask

    task automatic test_random(input int n);
        logic [AW-1:0]   p1;
        logic [2*DW-1:0] exp_rp;
        logic [DW-1:0]   e1;
        logic [DW-1:0]   e2;
        for (int c = 0; c < n; c++) begin
            bus.wr_en    = 1'($urandom_range(0, 1));
            bus.wr_pair  = 1'($urandom_range(0, 1));
            bus.wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_data  = 16'($urandom);
            bus.clr_req  = ($urandom_range(0, 15) == 0);
            bus.rs1_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.rs2_addr = AW'($urandom_range(0, DEPTH - 1));
            #1;
            p1     = bus.rs1_addr + 1'b1;
            e1     = exp_rd(bus.rs1_addr);
            e2     = exp_rd(bus.rs2_addr);
            exp_rp = {exp_rd(bus.rs1_addr), exp_rd(p1)};
            checks++;
            if (bus.rs1_data !== e1) begin
                errors++;
                $display("FAIL rand_rs1 cyc=%0d addr=%0d got=%h exp=%h", c, bus.rs1_addr, bus.rs1_data, e1);
            end
            checks++;
            if (bus.rs2_data !== e2) begin
                errors++;
                $display("FAIL rand_rs2 cyc=%0d addr=%0d got=%h exp=%h", c, bus.rs2_addr, bus.rs2_data, e2);
            end
            checks++;
            if (bus.rp_data !== exp_rp) begin
                errors++;
                $display("FAIL rand_rp cyc=%0d addr=%0d got=%h exp=%h", c, bus.rs1_addr, bus.rp_data, exp_rp);
            end
            checks++;
            if (bus.busy !== (m_left > 0)) begin
                errors++;
                $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, bus.busy, (m_left > 0));
            end
            checks++;
            if (bus.wr_err !== m_err) begin
                errors++;
                $display("FAIL rand_wr_err cyc=%0d got=%b exp=%b", c, bus.wr_err, m_err);
            end
            $display("rand %0d: we=%b pr=%b wa=%0d wd=%h clr=%b rs1=%0d->%h rs2=%0d->%h rp=%h busy=%b",
                     c, bus.wr_en, bus.wr_pair, bus.wr_addr, bus.wr_data, bus.clr_req,
                     bus.rs1_addr, bus.rs1_data, bus.rs2_addr, bus.rs2_data, bus.rp_data, bus.busy);
            tick();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_fwd();
        test_pair_wrap();
        test_clear();
        test_reset_mid_clear();
        test_clr_and_write();
        test_random(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_pair.md
# regfile_pair

Parametrised, clocked general-purpose register file for the 8-bit datapath. Provides two asynchronous read ports with same-cycle write forwarding, one write port that stores either one register or a 2-register pair (16-bit values, high half first), and a hardware clear sequencer that resets the array one entry per cycle. Sits between the decoder/operand-fetch stage and the ALU/writeback stage.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- DEPTH, 8, number of registers; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), derived; not overridden
- RESET_VAL, 0, value loaded by reset and by the clear sequence

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- rs1_data  out  DATA_W  contents of rs1_addr (forwarded)
- rs2_data  out  DATA_W  contents of rs2_addr (forwarded)
- rp_data  out  2*DATA_W  pair read {reg[rs1_addr], reg[rs1_addr+1]}
- wr_en  in  1  write request this cycle
- wr_pair  in  1  0: single write of wr_data[DATA_W-1:0]; 1: pair write
- wr_addr  in  ADDR_W  destination register (high half for pair)
- wr_data  in  2*DATA_W  write data
- clr_req  in  1  start clear sequence (sampled when idle)
- busy  out  1  clear sequence in progress
- wr_err  out  1  one-cycle pulse: write dropped because busy

## Operation
- Single write: reg[wr_addr] <= wr_data[DATA_W-1:0].
- Pair write: reg[wr_addr] <= wr_data[2*DATA_W-1:DATA_W]; reg[(wr_addr+1) mod DEPTH] <= wr_data[DATA_W-1:0]. Address DEPTH-1 wraps to 0.
- Reads combinational from array. Forwarding: when wr_en=1, busy=0 and the read address matches a register being written this cycle, the read returns the corresponding write half instead of the array. Applies to rs1_data, rs2_data and both halves of rp_data. Pair read address rs1_addr+1 wraps mod DEPTH.
- Clear FSM, states IDLE, CLEAR:
  - IDLE: clr_req=1 -> CLEAR, clr_ptr <= 0. Normal writes accepted.
  - CLEAR: each cycle reg[clr_ptr] <= RESET_VAL, clr_ptr++; at clr_ptr=DEPTH-1 write it and return to IDLE.
  - busy = (state==CLEAR), registered.
  - clr_req in CLEAR ignored (no restart, no queueing).
  - wr_en=1 while busy: write discarded, no forwarding, wr_err=1 next cycle for one cycle.
  - Reads during CLEAR return current array contents (cleared or not).
- Same-cycle clr_req and wr_en in IDLE: write performed, CLEAR entered; write later overwritten by clear.
- Reset (reset_n=0, any time incl. mid-clear): all registers = RESET_VAL, state IDLE, clr_ptr 0, busy 0, wr_err 0. Read outputs therefore show RESET_VAL.

## Timing
- Write latency: data in array after the rising edge where wr_en=1; visible same cycle via forwarding.
- Clear: clr_req sampled at edge N; busy=1 from N to N+DEPTH; entries cleared at edges N+1..N+DEPTH; busy=0 after edge N+DEPTH; write at that cycle accepted.
- wr_err asserted the cycle after the dropped write.
- Read paths are purely combinational address-to-data; no registers on outputs.

## Structure
- Package regfile_pkg: clear FSM state enum (ST_IDLE, ST_CLEAR), default DATA_W/DEPTH constants.
- Sub-module regfile_clear_fsm: state, clr_ptr counter, busy, wr_err; outputs clear-enable and clear address to the array. Array, write decode and forwarding muxes in regfile_pair.

## Test plan
- Reset then read all addresses -> every rs1_data/rs2_data = 0x00, busy=0, wr_err=0.
- Single write wr_addr=3, data 0x00A5, rs1_addr=3 same cycle -> rs1_data=0xA5 same cycle (forward) and after edge (array).
- Pair write wr_addr=7, data 0xBEEF -> reg7=0xBE, reg0=0xEF; rp_data with rs1_addr=7 = 0xBEEF.
- Fill regs with 0x11..0x88, pulse clr_req, wr_en at cycle 2 of clear -> busy high DEPTH cycles, wr_err pulse, all regs 0x00 after, dropped write absent.
- Assert reset_n=0 midway through clear, release -> all regs RESET_VAL, busy=0, next clr_req runs full DEPTH cycles.
- Simultaneous clr_req and single write 0x5A to reg 0 in IDLE -> reg0=0x5A for one cycle, then 0x00 after first clear edge.
